fpu_issue_sched: RTL and testbench



---
 rtl/fpu_issue_sched_pkg.sv | 48 ++++
 rtl/fpu_wb_slot_ring.sv | 62 ++++++
 rtl/fpu_issue_sched.sv | 125 ++++++++++++
 tb/tb_fpu_issue_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_sched_pkg.sv
// Purpose: shared FPU op classes, per-class latencies and helpers, used by the
//          issue scheduler and the FPU execute stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fpu_issue_sched_pkg;

  typedef enum logic [3:0] {
    FPU_NONE   = 4'd0,
    FPU_SIMPLE = 4'd1,  // neg/abs/cvt.w/round/trunc/ceil/floor
    FPU_COND   = 4'd2,
    FPU_CVTS   = 4'd3,
    FPU_ADDSUB = 4'd4,
    FPU_MUL    = 4'd5,
    FPU_DIV    = 4'd6,
    FPU_SQRT   = 4'd7
  } fpu_op_class_t;

  // Wide enough to hold the largest latency value itself.
  localparam int FPU_LAT_W = 4;

  localparam logic [FPU_LAT_W-1:0] FPU_SIMPLE_LATENCY = 4'd1;
  localparam logic [FPU_LAT_W-1:0] FPU_COND_LATENCY   = 4'd1;
  localparam logic [FPU_LAT_W-1:0] FPU_CVTS_LATENCY   = 4'd1;
  localparam logic [FPU_LAT_W-1:0] FPU_ADDSUB_LATENCY = 4'd2;
  localparam logic [FPU_LAT_W-1:0] FPU_MUL_LATENCY    = 4'd2;
  localparam logic [FPU_LAT_W-1:0] FPU_DIV_LATENCY    = 4'd8;
  localparam logic [FPU_LAT_W-1:0] FPU_SQRT_LATENCY   = 4'd8;

  // Unknown / NONE classes run through the simple path so the exception
  // logic downstream still sees a result.
  function automatic logic [FPU_LAT_W-1:0] fpu_class_latency(input logic [3:0] cls);
    case (cls)
      FPU_COND:   return FPU_COND_LATENCY;
      FPU_CVTS:   return FPU_CVTS_LATENCY;
      FPU_ADDSUB: return FPU_ADDSUB_LATENCY;
      FPU_MUL:    return FPU_MUL_LATENCY;
      FPU_DIV:    return FPU_DIV_LATENCY;
      FPU_SQRT:   return FPU_SQRT_LATENCY;
      default:    return FPU_SIMPLE_LATENCY;
    endcase
  endfunction

  // True for ops that occupy the non-pipelined divide/sqrt unit.
  function automatic logic fpu_class_blocking(input logic [3:0] cls);
    return (cls == FPU_DIV) || (cls == FPU_SQRT);
  endfunction

endpackage

// File: rtl/fpu_wb_slot_ring.sv
// Purpose: writeback-slot reservation ring; entry k is the result due k cycles
//          from now. Ports: alloc/alloc_lat/alloc_tag/alloc_class reserve a slot,
//          flush clears all, slot_free[L-1] says latency L can be reserved,
//          head_* is the entry completing this cycle, any_valid = ring non-empty.
// Latency: a reservation with latency L reaches the head L cycles after alloc.
// Backpressure: none; caller must only alloc when slot_free allows it.
module fpu_wb_slot_ring
  import fpu_issue_sched_pkg::*;
#(
  parameter int MAX_LAT = 8,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 alloc,
  input  logic [FPU_LAT_W-1:0] alloc_lat,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic [3:0]           alloc_class,
  output logic [MAX_LAT-1:0]   slot_free,
  output logic                 head_valid,
  output logic [TAG_W-1:0]     head_tag,
  output logic [3:0]           head_class,
  output logic                 any_valid
);

  logic [MAX_LAT-1:0]            vld;
  logic [MAX_LAT-1:0][TAG_W-1:0] tag;
  logic [MAX_LAT-1:0][3:0]       cls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      tag <= '0;
      cls <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld <= {1'b0, vld[MAX_LAT-1:1]};
      tag <= {{TAG_W{1'b0}}, tag[MAX_LAT-1:1]};
      cls <= {4'd0, cls[MAX_LAT-1:1]};
      // The new reservation lands at L-1 after the shift, i.e. at the head
      // exactly L edges from now.
      for (int i = 0; i < MAX_LAT; i++) begin
        if (alloc && alloc_lat == FPU_LAT_W'(i + 1)) begin
          vld[i] <= 1'b1;
          tag[i] <= alloc_tag;
          cls[i] <= alloc_class;
        end
      end
    end
  end

  // Latency L collides with whatever currently sits at entry L (it shifts
  // into L-1 on the same edge). L == MAX_LAT has no such entry.
  assign slot_free  = {1'b1, ~vld[MAX_LAT-1:1]};
  assign head_valid = vld[0];
  assign head_tag   = tag[0];
  assign head_class = cls[0];
  assign any_valid  = |vld;

endmodule

// File: rtl/fpu_issue_sched.sv
// Purpose: round-robin issue of one FPU op per cycle from NUM_REQ requesters,
//          reserving the single writeback slot and guarding the div/sqrt unit.
//          Ports: req_* in / req_ready grant, issue_* to FPU, wb_* from ring head, busy.
// Latency: grant is combinational; result shows on wb_* L cycles after issue.
// Backpressure: ineligible requesters see req_ready=0 and must hold their request.
module fpu_issue_sched
  import fpu_issue_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4,
  parameter int MAX_LAT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][3:0]         req_class,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            issue_valid,
  output logic [$clog2(NUM_REQ)-1:0]      issue_sel,
  output logic [3:0]                      issue_class,
  output logic                            wb_valid,
  output logic [TAG_W-1:0]                wb_tag,
  output logic [3:0]                      wb_class,
  output logic                            busy
);

  localparam int SEL_W = $clog2(NUM_REQ);

  logic [SEL_W-1:0]     rr_ptr;
  logic [FPU_LAT_W-1:0] ds_cnt;
  logic [MAX_LAT-1:0]   slot_free;
  logic                 any_valid;

  logic [NUM_REQ-1:0]   elig;
  logic [FPU_LAT_W-1:0] lat_i;
  logic [MAX_LAT-1:0]   slot_sh;
  logic [SEL_W:0]       scan;
  logic                 found;
  logic [SEL_W-1:0]     gnt;
  logic [FPU_LAT_W-1:0] issue_lat;

  // Eligibility: valid, no flush, writeback slot free, divider idle if needed.
  // rst_n gating keeps grants quiet while the block is held in reset.
  always_comb begin
    elig    = '0;
    lat_i   = '0;
    slot_sh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lat_i   = fpu_class_latency(req_class[i]);
      slot_sh = slot_free >> (lat_i - FPU_LAT_W'(1));
      elig[i] = rst_n && req_valid[i] && !flush && slot_sh[0] &&
                !(fpu_class_blocking(req_class[i]) && ds_cnt != '0);
    end
  end

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    scan  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan = {1'b0, rr_ptr} + (SEL_W+1)'(off);
      if (scan >= (SEL_W+1)'(NUM_REQ)) scan = scan - (SEL_W+1)'(NUM_REQ);
      if (!found && elig[scan[SEL_W-1:0]]) begin
        found = 1'b1;
        gnt   = scan[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found) req_ready[gnt] = 1'b1;
  end

  assign issue_valid = found;
  assign issue_sel   = gnt;
  assign issue_class = found ? req_class[gnt] : 4'd0;
  assign issue_lat   = fpu_class_latency(issue_class);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt == SEL_W'(NUM_REQ - 1)) ? '0 : gnt + SEL_W'(1);
    end
  end

  // Divider occupancy: loaded with L-1 so the next div/sqrt may go exactly
  // L cycles after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_cnt <= '0;
    end else if (flush) begin
      ds_cnt <= '0;
    end else if (found && fpu_class_blocking(issue_class)) begin
      ds_cnt <= issue_lat - FPU_LAT_W'(1);
    end else if (ds_cnt != '0) begin
      ds_cnt <= ds_cnt - FPU_LAT_W'(1);
    end
  end

  fpu_wb_slot_ring #(
    .MAX_LAT (MAX_LAT),
    .TAG_W   (TAG_W)
  ) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alloc       (found),
    .alloc_lat   (issue_lat),
    .alloc_tag   (req_tag[gnt]),
    .alloc_class (issue_class),
    .slot_free   (slot_free),
    .head_valid  (wb_valid),
    .head_tag    (wb_tag),
    .head_class  (wb_class),
    .any_valid   (any_valid)
  );

  assign busy = any_valid || (ds_cnt != '0);

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Purpose: directed self-checking bench for fpu_issue_sched.
// Latency: checks grants combinationally and wb_* at issue + L cycles.
// Backpressure: exercises slot conflicts, div/sqrt hold-off, flush and reset.
module tb_fpu_issue_sched;
  import fpu_issue_sched_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;
  localparam int MAX_LAT = 8;

  logic                          clk;
  logic                          rst_n;
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][3:0]       req_class;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          issue_valid;
  logic [0:0]                    issue_sel;
  logic [3:0]                    issue_class;
  logic                          wb_valid;
  logic [TAG_W-1:0]              wb_tag;
  logic [3:0]                    wb_class;
  logic                          busy;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_issue_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MAX_LAT(MAX_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_class   (req_class),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .issue_class (issue_class),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_class    (wb_class),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] c, input logic [3:0] t);
    req_valid[i] = v;
    req_class[i] = c;
    req_tag[i]   = t;
  endtask

  // Leaves the bench 1 time unit after a clock edge with reset released:
  // the caller is then in cycle 0 of a test.
  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_class = '0;
    req_tag   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset state.
    rst_n = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_issue", issue_valid, 0);
    check("rst_wb", wb_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // T1: single ADDSUB, tag 3.
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      set_req(0, c == 0, FPU_ADDSUB, 4'd3);
      @(negedge clk);
      if (c == 0) begin
        check("t1_ready", req_ready, 2'b01);
        check("t1_issue_class", issue_class, FPU_ADDSUB);
        check("t1_busy_c0", busy, 0);
      end
      if (c == 1) begin
        check("t1_wb_c1", wb_valid, 0);
        check("t1_busy_c1", busy, 1);
      end
      if (c == 2) begin
        check("t1_wb_c2", wb_valid, 1);
        check("t1_wbtag_c2", wb_tag, 3);
        check("t1_wbclass_c2", wb_class, FPU_ADDSUB);
      end
      if (c == 3) begin
        check("t1_busy_c3", busy, 0);
        check("t1_wb_c3", wb_valid, 0);
      end
      next_cyc();
    end

    // T2: MUL tag 1 then SIMPLE tag 2 collides with the MUL's slot.
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c == 0) set_req(0, 1'b1, FPU_MUL, 4'd1);
      else        set_req(0, c <= 2, FPU_SIMPLE, 4'd2);
      @(negedge clk);
      if (c == 0) check("t2_ready_c0", req_ready, 2'b01);
      if (c == 1) check("t2_stall_c1", req_ready, 2'b00);
      if (c == 2) begin
        check("t2_ready_c2", req_ready, 2'b01);
        check("t2_wb_c2", wb_valid, 1);
        check("t2_wbtag_c2", wb_tag, 1);
      end
      if (c == 3) begin
        check("t2_wb_c3", wb_valid, 1);
        check("t2_wbtag_c3", wb_tag, 2);
        check("t2_wbclass_c3", wb_class, FPU_SIMPLE);
      end
      next_cyc();
    end

    // T3: both requesters ADDSUB continuously -> alternating grants.
    do_reset();
    set_req(0, 1'b1, FPU_ADDSUB, 4'd4);
    set_req(1, 1'b1, FPU_ADDSUB, 4'd9);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check("t3_issue", issue_valid, 1);
      check("t3_sel", issue_sel, (c % 2));
      if (c >= 2) begin
        check("t3_wb", wb_valid, 1);
        check("t3_wbtag", wb_tag, (c % 2 == 0) ? 4 : 9);
      end
      next_cyc();
    end
    req_valid = '0;

    // T4: back-to-back DIVs, second held off until the divider frees.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      set_req(0, c == 0, FPU_DIV, 4'd5);
      set_req(1, c <= 8, FPU_DIV, 4'd6);
      @(negedge clk);
      if (c == 0) check("t4_sel_c0", {issue_valid, issue_sel}, 2'b10);
      if (c >= 1 && c <= 7) check("t4_hold", issue_valid, 0);
      if (c == 8) begin
        check("t4_sel_c8", {issue_valid, issue_sel}, 2'b11);
        check("t4_wbtag_c8", {wb_valid, wb_tag}, {1'b1, 4'd5});
      end
      if (c >= 9 && c <= 15) check("t4_wb_gap", wb_valid, 0);
      if (c == 16) check("t4_wbtag_c16", {wb_valid, wb_tag}, {1'b1, 4'd6});
      next_cyc();
    end

    // T5: DIV then ADDSUB whose writeback would collide with the DIV's.
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      set_req(0, c == 0, FPU_DIV, 4'd7);
      set_req(1, c == 6 || c == 7, FPU_ADDSUB, 4'd8);
      @(negedge clk);
      if (c == 6) check("t5_stall_c6", req_ready, 2'b00);
      if (c == 7) check("t5_ready_c7", req_ready, 2'b10);
      if (c == 8) begin
        check("t5_wbtag_c8", {wb_valid, wb_tag}, {1'b1, 4'd7});
        check("t5_wbclass_c8", wb_class, FPU_DIV);
      end
      if (c == 9) check("t5_wbtag_c9", {wb_valid, wb_tag}, {1'b1, 4'd8});
      next_cyc();
    end

    // T6: flush discards an in-flight DIV and frees the divider.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      flush = (c == 3);
      set_req(0, c == 0 || c == 3 || c == 4, FPU_DIV, (c == 0) ? 4'd5 : 4'd2);
      @(negedge clk);
      if (c == 3) check("t6_flush_ready", req_ready, 2'b00);
      if (c == 4) begin
        check("t6_busy_c4", busy, 0);
        check("t6_ready_c4", req_ready, 2'b01);
      end
      if (c >= 4 && c <= 10) check("t6_no_wb", wb_valid, 0);
      if (c == 12) check("t6_wbtag_c12", {wb_valid, wb_tag}, {1'b1, 4'd2});
      next_cyc();
    end
    flush = 1'b0;

    // T7: reset asserted mid-MUL.
    do_reset();
    set_req(0, 1'b1, FPU_MUL, 4'd1);
    @(negedge clk);
    check("t7_ready_c0", req_ready, 2'b01);
    next_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_ready", req_ready, 0);
    check("t7_rst_issue", issue_valid, 0);
    check("t7_rst_wb", wb_valid, 0);
    check("t7_rst_busy", busy, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t7_no_wb", wb_valid, 0);
      next_cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
